// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction-fetch stage feeding the IF/ID pipeline register.
//             Owns the architectural PC and keeps at most one request in
//             flight to a variable-latency instruction memory. Each cycle it
//             presents either the fetched word or a NOP bubble, with its PC,
//             and drives the IF/ID write enable. It also handles hazard
//             stalls, branch redirects from EX and HLT detection.
//  Ports    :
//    clk            in   system clock (rising edge)
//    rst            in   synchronous active-high reset
//    stall          in   hold PC and suppress the IF/ID write
//    branch_taken   in   redirect request from EX
//    branch_target  in   [15:0] redirect PC
//    imem_req       out  request strobe (address taken on this edge)
//    imem_addr      out  [15:0] request address (= pc)
//    imem_rdy       in   response valid
//    imem_data      in   [15:0] instruction word
//    instr_out      out  [15:0] instruction or bubble to IF/ID
//    pc_current_out out  [15:0] PC of instr_out
//    pc_plus2_out   out  [15:0] pc_current_out + 2 (mod 2^16)
//    if_id_wen      out  IF/ID write enable
//    halted         out  fetch stopped on HLT
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_INSTR  = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic [15:0] instr_out,
  output logic [15:0] pc_current_out,
  output logic [15:0] pc_plus2_out,
  output logic        if_id_wen,
  output logic        halted
);

  localparam logic [2:0] c_ST_ISSUE   = 3'd0;
  localparam logic [2:0] c_ST_WAIT    = 3'd1;
  localparam logic [2:0] c_ST_HOLD    = 3'd2;
  localparam logic [2:0] c_ST_DISCARD = 3'd3;
  localparam logic [2:0] c_ST_HALT    = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] hold_q, hold_d;

  // A delivery can come straight from memory (WAIT) or from the hold
  // buffer (HOLD); both share the same write/HLT/advance handling below.
  logic        w_deliver;
  logic [15:0] w_word;

  assign imem_addr      = pc_q;
  assign pc_current_out = pc_q;
  assign pc_plus2_out   = pc_q + 16'd2;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    w_deliver = 1'b0;
    w_word    = imem_data;
    imem_req  = 1'b0;
    if_id_wen = ~stall;
    instr_out = NOP_INSTR;
    halted    = 1'b0;

    case (state_q)
      c_ST_ISSUE: begin
        // The request goes out even when redirected; its response must
        // then be thrown away, hence DISCARD.
        imem_req = 1'b1;
        state_d  = c_ST_WAIT;
        if (branch_taken) begin
          pc_d    = branch_target;
          state_d = c_ST_DISCARD;
        end
      end

      c_ST_WAIT: begin
        if (branch_taken) begin
          pc_d      = branch_target;
          if_id_wen = 1'b1;
          state_d   = imem_rdy ? c_ST_ISSUE : c_ST_DISCARD;
        end else if (imem_rdy && !stall) begin
          w_deliver = 1'b1;
          w_word    = imem_data;
        end else if (imem_rdy) begin
          hold_d    = imem_data;
          if_id_wen = 1'b0;
          state_d   = c_ST_HOLD;
        end
      end

      c_ST_HOLD: begin
        if (branch_taken) begin
          hold_d    = NOP_INSTR;
          pc_d      = branch_target;
          if_id_wen = 1'b1;
          state_d   = c_ST_ISSUE;
        end else if (!stall) begin
          w_deliver = 1'b1;
          w_word    = hold_q;
        end
      end

      c_ST_DISCARD: begin
        if (branch_taken) begin
          pc_d = branch_target;
        end
        // A response arriving together with a new redirect still retires
        // the outstanding request, so the DISCARD can end here.
        if (imem_rdy) begin
          state_d = c_ST_ISSUE;
        end
      end

      c_ST_HALT: begin
        halted = 1'b1;
        if (branch_taken) begin
          pc_d    = branch_target;
          state_d = c_ST_ISSUE;
        end
      end

      default: begin
        state_d = c_ST_ISSUE;
      end
    endcase

    if (w_deliver) begin
      instr_out = w_word;
      if_id_wen = 1'b1;
      if (w_word[15:12] == HLT_OPCODE) begin
        state_d = c_ST_HALT;
      end else begin
        pc_d    = pc_q + 16'd2;
        state_d = c_ST_ISSUE;
      end
    end

    if (rst) begin
      imem_req  = 1'b0;
      if_id_wen = 1'b0;
      instr_out = NOP_INSTR;
      halted    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_ST_ISSUE;
      pc_q    <= RESET_PC;
      hold_q  <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Directed self-checking bench for fetch_stage with a small
//             variable-latency instruction memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic [15:0] instr_out;
  logic [15:0] pc_current_out;
  logic [15:0] pc_plus2_out;
  logic        if_id_wen;
  logic        halted;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdy       (imem_rdy),
    .imem_data      (imem_data),
    .instr_out      (instr_out),
    .pc_current_out (pc_current_out),
    .pc_plus2_out   (pc_plus2_out),
    .if_id_wen      (if_id_wen),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word at addr[8:1]; response imem_rdy pulses 'lat' cycles
  // after the accepted request.
  logic [15:0] mem [0:255];
  int          lat;
  int          cnt;
  int          req_count;
  logic [15:0] addr_q;

  always @(posedge clk) begin
    if (rst) begin
      cnt <= 0;
    end else if (imem_req) begin
      cnt       <= lat;
      addr_q    <= imem_addr;
      req_count <= req_count + 1;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
    end
  end

  assign imem_rdy  = (cnt == 1);
  assign imem_data = mem[addr_q[8:1]];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  int saved_reqs;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
    mem[0]   = 16'h1234;
    mem[1]   = 16'h5678;
    mem[8]   = 16'hF000;
    cnt           = 0;
    req_count     = 0;
    addr_q        = 16'h0000;
    lat           = 1;
    rst           = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 16'h0000;

    // Reset
    next_cycle();
    #1;
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_wen", if_id_wen, 1'b0);
    chk("rst_instr", instr_out, 16'h0000);
    chk1("rst_halted", halted, 1'b0);
    chk("rst_pc", pc_current_out, 16'h0000);
    next_cycle();
    rst = 1'b0;

    // C0 ISSUE 0x0000, 1-cycle memory
    #1;
    chk1("c0_req", imem_req, 1'b1);
    chk("c0_addr", imem_addr, 16'h0000);
    chk1("c0_wen", if_id_wen, 1'b1);
    chk("c0_instr", instr_out, 16'h0000);
    next_cycle();
    // C1 delivery 1234
    #1;
    chk1("c1_wen", if_id_wen, 1'b1);
    chk("c1_instr", instr_out, 16'h1234);
    chk("c1_pc", pc_current_out, 16'h0000);
    chk("c1_pc2", pc_plus2_out, 16'h0002);
    next_cycle();
    // C2 ISSUE 0x0002
    #1;
    chk1("c2_req", imem_req, 1'b1);
    chk("c2_addr", imem_addr, 16'h0002);
    next_cycle();
    // C3 delivery 5678
    #1;
    chk("c3_instr", instr_out, 16'h5678);
    chk("c3_pc", pc_current_out, 16'h0002);
    chk("c3_pc2", pc_plus2_out, 16'h0004);
    next_cycle();

    // C4 ISSUE 0x0004 with 3-cycle memory
    lat = 3;
    #1;
    chk("c4_addr", imem_addr, 16'h0004);
    next_cycle();
    // C5, C6 bubbles
    #1;
    chk1("c5_req", imem_req, 1'b0);
    chk1("c5_wen", if_id_wen, 1'b1);
    chk("c5_instr", instr_out, 16'h0000);
    chk("c5_pc", pc_current_out, 16'h0004);
    next_cycle();
    #1;
    chk1("c6_wen", if_id_wen, 1'b1);
    chk("c6_instr", instr_out, 16'h0000);
    chk("c6_pc", pc_current_out, 16'h0004);
    next_cycle();
    // C7 delivery of mem[2]
    #1;
    chk("c7_instr", instr_out, 16'h1002);
    chk("c7_pc", pc_current_out, 16'h0004);
    next_cycle();

    // C8 ISSUE 0x0006, 1-cycle memory, then stall on arrival
    lat = 1;
    #1;
    chk("c8_addr", imem_addr, 16'h0006);
    next_cycle();
    // C9 data arrives while stalled
    stall = 1'b1;
    #1;
    saved_reqs = req_count;
    chk1("c9_wen", if_id_wen, 1'b0);
    chk1("c9_req", imem_req, 1'b0);
    next_cycle();
    // C10 still stalled in HOLD
    #1;
    chk1("c10_wen", if_id_wen, 1'b0);
    chk1("c10_req", imem_req, 1'b0);
    next_cycle();
    // C11 release: buffered word written
    stall = 1'b0;
    #1;
    chk1("c11_wen", if_id_wen, 1'b1);
    chk("c11_instr", instr_out, 16'h1003);
    chk("c11_pc", pc_current_out, 16'h0006);
    chk("c11_pc2", pc_plus2_out, 16'h0008);
    chk1("c11_req", imem_req, 1'b0);
    chk("c11_reqcnt", 16'(req_count), 16'(saved_reqs));
    next_cycle();

    // C12 ISSUE 0x0008, 3-cycle memory, branch while waiting
    lat = 3;
    #1;
    chk("c12_addr", imem_addr, 16'h0008);
    next_cycle();
    // C13 WAIT + branch to 0x0040 (stall high: flush still writes)
    branch_taken  = 1'b1;
    branch_target = 16'h0040;
    stall         = 1'b1;
    #1;
    chk1("c13_wen", if_id_wen, 1'b1);
    chk("c13_instr", instr_out, 16'h0000);
    next_cycle();
    branch_taken = 1'b0;
    stall        = 1'b0;
    // C14 DISCARD, response pending
    #1;
    chk1("c14_req", imem_req, 1'b0);
    chk("c14_pc", pc_current_out, 16'h0040);
    chk("c14_instr", instr_out, 16'h0000);
    next_cycle();
    // C15 stale response dropped
    #1;
    chk("c15_instr", instr_out, 16'h0000);
    chk1("c15_req", imem_req, 1'b0);
    next_cycle();
    // C16 ISSUE at target
    lat = 1;
    #1;
    chk1("c16_req", imem_req, 1'b1);
    chk("c16_addr", imem_addr, 16'h0040);
    next_cycle();
    // C17 delivery of mem[32]
    #1;
    chk("c17_instr", instr_out, 16'h1020);
    chk("c17_pc", pc_current_out, 16'h0040);
    next_cycle();

    // C18 ISSUE 0x0042 with branch to 0x0010
    branch_taken  = 1'b1;
    branch_target = 16'h0010;
    #1;
    chk("c18_addr", imem_addr, 16'h0042);
    next_cycle();
    branch_taken = 1'b0;
    // C19 DISCARD drops response
    #1;
    chk("c19_instr", instr_out, 16'h0000);
    next_cycle();
    // C20 ISSUE 0x0010
    #1;
    chk("c20_addr", imem_addr, 16'h0010);
    next_cycle();
    // C21 HLT word delivered
    #1;
    chk("c21_instr", instr_out, 16'hF000);
    chk1("c21_wen", if_id_wen, 1'b1);
    chk("c21_pc", pc_current_out, 16'h0010);
    next_cycle();
    // C22 halted
    #1;
    chk1("c22_halted", halted, 1'b1);
    chk1("c22_req", imem_req, 1'b0);
    chk("c22_pc", pc_current_out, 16'h0010);
    chk("c22_instr", instr_out, 16'h0000);
    next_cycle();
    // C23 halted, branch to 0x0020 resumes
    branch_taken  = 1'b1;
    branch_target = 16'h0020;
    #1;
    chk1("c23_halted", halted, 1'b1);
    chk1("c23_req", imem_req, 1'b0);
    next_cycle();
    branch_taken = 1'b0;
    // C24 ISSUE 0x0020
    #1;
    chk1("c24_halted", halted, 1'b0);
    chk1("c24_req", imem_req, 1'b1);
    chk("c24_addr", imem_addr, 16'h0020);
    next_cycle();
    // C25 delivery of mem[16]
    #1;
    chk("c25_instr", instr_out, 16'h1010);
    next_cycle();

    // C26 ISSUE 0x0022 with branch to 0xFFFE
    branch_taken  = 1'b1;
    branch_target = 16'hFFFE;
    #1;
    chk("c26_addr", imem_addr, 16'h0022);
    next_cycle();
    branch_taken = 1'b0;
    // C27 DISCARD
    next_cycle();
    // C28 ISSUE 0xFFFE
    #1;
    chk("c28_addr", imem_addr, 16'hFFFE);
    next_cycle();
    // C29 delivery at 0xFFFE, pc+2 wraps
    #1;
    chk("c29_instr", instr_out, 16'h10FF);
    chk("c29_pc", pc_current_out, 16'hFFFE);
    chk("c29_pc2", pc_plus2_out, 16'h0000);
    next_cycle();
    // C30 ISSUE at wrapped pc
    lat = 3;
    #1;
    chk1("c30_req", imem_req, 1'b1);
    chk("c30_addr", imem_addr, 16'h0000);
    next_cycle();

    // C31 reset during WAIT
    rst = 1'b1;
    #1;
    chk1("c31_wen", if_id_wen, 1'b0);
    chk1("c31_req", imem_req, 1'b0);
    chk("c31_instr", instr_out, 16'h0000);
    next_cycle();
    rst = 1'b0;
    // C32 ISSUE at RESET_PC
    #1;
    chk1("c32_req", imem_req, 1'b1);
    chk("c32_addr", imem_addr, 16'h0000);
    chk1("c32_halted", halted, 1'b0);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
